// File: rtl/video_bounce_box_pkg.sv
// ---------------------------------------------------------------------------
// video_bounce_box_pkg
//
// Shared definitions for the bouncing-box overlay stage.
//   COORD_W      : width of every pixel/line coordinate (x_cnt, y_cnt, box_x,
//                  box_y)
//   ARITH_W      : one bit wider than COORD_W so sums and limits never wrap
//   updState_t   : position-update FSM encoding (IDLE -> UPD_X -> UPD_Y)
//   dir_t        : movement direction along one axis
//   axisState_t  : position plus direction for one axis
//   bounceStep() : advances one axis by one step and reflects it at the
//                  edges of the active area
// ---------------------------------------------------------------------------
package video_bounce_box_pkg;

  localparam int COORD_W = 12;
  localparam int ARITH_W = COORD_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_UPD_X = 2'd1,
    ST_UPD_Y = 2'd2
  } updState_t;

  // DIR_FWD means increasing coordinate (right or down), DIR_BACK decreasing
  // (left or up).
  typedef enum logic {
    DIR_FWD  = 1'b0,
    DIR_BACK = 1'b1
  } dir_t;

  typedef struct packed {
    logic [COORD_W-1:0] pos;
    dir_t               dir;
  } axisState_t;

  localparam axisState_t AXIS_HOME = '{pos: {COORD_W{1'b0}}, dir: DIR_FWD};

  // One move along an axis whose legal positions are 0..limit. Moving
  // forward, a step that would reach or pass the far edge parks the box
  // exactly on it and turns it round; moving back, a step that would reach
  // or pass zero parks it on zero and turns it round. All arithmetic is done
  // at ARITH_W bits so pos+step cannot overflow the comparison.
  function automatic axisState_t bounceStep(input axisState_t cur,
                                            input logic [ARITH_W-1:0] step,
                                            input logic [ARITH_W-1:0] limit);
    axisState_t         nxt;
    logic [ARITH_W-1:0] wide;
    nxt  = cur;
    wide = {1'b0, cur.pos};
    if (cur.dir == DIR_FWD) begin
      if ((wide + step) >= limit) begin
        nxt.pos = limit[COORD_W-1:0];
        nxt.dir = DIR_BACK;
      end else begin
        nxt.pos = COORD_W'(wide + step);
      end
    end else begin
      if (wide <= step) begin
        nxt.pos = {COORD_W{1'b0}};
        nxt.dir = DIR_FWD;
      end else begin
        nxt.pos = COORD_W'(wide - step);
      end
    end
    return nxt;
  endfunction

endpackage

// File: rtl/video_bounce_box_pos_counter.sv
// ---------------------------------------------------------------------------
// video_pos_counter
//
// Tracks the active-pixel coordinate of the incoming stream from DE and VS.
//   i_clk, i_rst : pixel clock, synchronous active-high reset
//   i_de, i_vs   : raw input data-enable and vertical sync
//   o_xCnt       : pixel index within the current line (first pixel is 0)
//   o_yCnt       : line index within the frame, saturating at all-ones
//   o_deFall     : DE has just dropped (end of an active line)
//   o_vsLead     : VS has just entered its active level (VS_POL selects it)
//   o_dePrev     : registered copy of i_de (also stage 1 of the sync delay)
//   o_vsPrev     : registered copy of i_vs (also stage 1 of the sync delay)
// ---------------------------------------------------------------------------
module video_pos_counter
  import video_bounce_box_pkg::*;
#(
  parameter int VS_POL = 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_de,
  input  logic               i_vs,
  output logic [COORD_W-1:0] o_xCnt,
  output logic [COORD_W-1:0] o_yCnt,
  output logic               o_deFall,
  output logic               o_vsLead,
  output logic               o_dePrev,
  output logic               o_vsPrev
);

  localparam logic VS_ACT = (VS_POL != 0);
  localparam logic [COORD_W-1:0] COORD_MAX = {COORD_W{1'b1}};

  logic               r_dePrev;
  logic               r_vsPrev;
  logic [COORD_W-1:0] r_xCnt;
  logic [COORD_W-1:0] r_yCnt;
  logic               w_deFall;
  logic               w_vsLead;

  // Edge strobes compare the live input with last cycle's copy. The copies
  // reset to 0, so with an active-low VS the idle-high level right after
  // reset is not mistaken for a leading edge.
  assign w_deFall = !i_de && r_dePrev;
  assign w_vsLead = (i_vs == VS_ACT) && (r_vsPrev != VS_ACT);

  // The x counter holds the index of the pixel being presented: it counts up
  // on every active pixel and returns to zero just after the line ends, so
  // the next line starts at 0. The y counter counts completed lines and is
  // zeroed when a new frame's vertical sync begins; a frame-start clear wins
  // over a simultaneous line end. It sticks at its maximum rather than wrap.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_dePrev <= 1'b0;
      r_vsPrev <= 1'b0;
      r_xCnt   <= '0;
      r_yCnt   <= '0;
    end else begin
      r_dePrev <= i_de;
      r_vsPrev <= i_vs;
      if (i_de) begin
        r_xCnt <= r_xCnt + COORD_W'(1);
      end else if (w_deFall) begin
        r_xCnt <= '0;
      end
      if (w_vsLead) begin
        r_yCnt <= '0;
      end else if (w_deFall && (r_yCnt != COORD_MAX)) begin
        r_yCnt <= r_yCnt + COORD_W'(1);
      end
    end
  end

  assign o_xCnt   = r_xCnt;
  assign o_yCnt   = r_yCnt;
  assign o_deFall = w_deFall;
  assign o_vsLead = w_vsLead;
  assign o_dePrev = r_dePrev;
  assign o_vsPrev = r_vsPrev;

endmodule

// File: rtl/video_bounce_box.sv
// ---------------------------------------------------------------------------
// video_bounce_box
//
// Overlay stage that paints a BOX_W x BOX_H rectangle of a programmable
// colour into a pixel stream and moves it once per frame, bouncing off the
// edges of the active area. Syncs and data leave exactly two cycles after
// they arrive.
//   I_pxl_clk                     : pixel clock
//   I_rst                         : synchronous active-high reset
//   I_en                          : 1 = draw and move the box, 0 = pass-through
//   I_box_r/g/b                   : box fill colour
//   I_vs/I_hs/I_de                : input syncs
//   I_data_r/g/b                  : input pixel
//   O_vs/O_hs/O_de                : syncs delayed by two cycles
//   O_data_r/g/b                  : pixel delayed by two cycles, box painted
//   O_frame_tick                  : one-cycle pulse per position update
// ---------------------------------------------------------------------------
module video_bounce_box
  import video_bounce_box_pkg::*;
#(
  parameter int H_RES  = 720,
  parameter int V_RES  = 480,
  parameter int BOX_W  = 64,
  parameter int BOX_H  = 48,
  parameter int STEP_X = 2,
  parameter int STEP_Y = 1,
  parameter int VS_POL = 1
) (
  input  logic       I_pxl_clk,
  input  logic       I_rst,
  input  logic       I_en,
  input  logic [7:0] I_box_r,
  input  logic [7:0] I_box_g,
  input  logic [7:0] I_box_b,
  input  logic       I_vs,
  input  logic       I_hs,
  input  logic       I_de,
  input  logic [7:0] I_data_r,
  input  logic [7:0] I_data_g,
  input  logic [7:0] I_data_b,
  output logic       O_vs,
  output logic       O_hs,
  output logic       O_de,
  output logic [7:0] O_data_r,
  output logic [7:0] O_data_g,
  output logic [7:0] O_data_b,
  output logic       O_frame_tick
);

  localparam logic [ARITH_W-1:0] X_LIMIT = ARITH_W'(H_RES - BOX_W);
  localparam logic [ARITH_W-1:0] Y_LIMIT = ARITH_W'(V_RES - BOX_H);
  localparam logic [ARITH_W-1:0] X_STEP  = ARITH_W'(STEP_X);
  localparam logic [ARITH_W-1:0] Y_STEP  = ARITH_W'(STEP_Y);
  localparam logic [ARITH_W-1:0] W_SPAN  = ARITH_W'(BOX_W);
  localparam logic [ARITH_W-1:0] H_SPAN  = ARITH_W'(BOX_H);

  logic [COORD_W-1:0] w_xCnt;
  logic [COORD_W-1:0] w_yCnt;
  logic               w_unusedDeFall;
  logic               w_vsLead;
  logic               w_dePrev;
  logic               w_vsPrev;

  updState_t          r_state;
  updState_t          w_nextState;
  axisState_t         r_axX;
  axisState_t         r_axY;
  axisState_t         w_nextAxX;
  axisState_t         w_nextAxY;
  logic               r_enQ;
  logic               w_tick;

  logic [ARITH_W-1:0] w_x13;
  logic [ARITH_W-1:0] w_y13;
  logic [ARITH_W-1:0] w_boxX13;
  logic [ARITH_W-1:0] w_boxY13;
  logic               w_inside;

  logic               r_hs1;
  logic               r_inside1;
  logic [7:0]         r_dataR1;
  logic [7:0]         r_dataG1;
  logic [7:0]         r_dataB1;

  logic               r_vs2;
  logic               r_hs2;
  logic               r_de2;
  logic [7:0]         r_dataR2;
  logic [7:0]         r_dataG2;
  logic [7:0]         r_dataB2;

  // The counter's registered DE/VS copies double as stage 1 of the sync
  // delay line, so the edge detectors cost no extra flops. Its line-end
  // strobe is not needed at this level.
  video_pos_counter #(
    .VS_POL(VS_POL)
  ) u_posCounter (
    .i_clk    (I_pxl_clk),
    .i_rst    (I_rst),
    .i_de     (I_de),
    .i_vs     (I_vs),
    .o_xCnt   (w_xCnt),
    .o_yCnt   (w_yCnt),
    .o_deFall (w_unusedDeFall),
    .o_vsLead (w_vsLead),
    .o_dePrev (w_dePrev),
    .o_vsPrev (w_vsPrev)
  );

  // Rectangle membership for the pixel currently on the input. Widening to
  // ARITH_W keeps box_x + BOX_W from wrapping near the right edge.
  assign w_x13    = {1'b0, w_xCnt};
  assign w_y13    = {1'b0, w_yCnt};
  assign w_boxX13 = {1'b0, r_axX.pos};
  assign w_boxY13 = {1'b0, r_axY.pos};
  assign w_inside = I_de
                 && (w_x13 >= w_boxX13) && (w_x13 < (w_boxX13 + W_SPAN))
                 && (w_y13 >= w_boxY13) && (w_y13 < (w_boxY13 + H_SPAN));

  // Next-state logic for the position updater. A vertical-sync leading edge
  // with the freshly sampled enable set starts an update; X moves on the
  // first cycle, Y on the second, and the tick marks the Y cycle. Edges that
  // arrive mid-update are ignored. Everything defaults to "hold".
  always_comb begin
    w_nextState = r_state;
    w_nextAxX   = r_axX;
    w_nextAxY   = r_axY;
    w_tick      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_vsLead && I_en) begin
          w_nextState = ST_UPD_X;
        end
      end
      ST_UPD_X: begin
        w_nextAxX   = bounceStep(r_axX, X_STEP, X_LIMIT);
        w_nextState = ST_UPD_Y;
      end
      ST_UPD_Y: begin
        w_nextAxY   = bounceStep(r_axY, Y_STEP, Y_LIMIT);
        w_tick      = 1'b1;
        w_nextState = ST_IDLE;
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // Updater state, box position and the frame-latched enable. The enable is
  // only captured at a frame start, so toggling I_en mid-frame can never
  // leave a frame half painted.
  always_ff @(posedge I_pxl_clk) begin
    if (I_rst) begin
      r_state <= ST_IDLE;
      r_axX   <= AXIS_HOME;
      r_axY   <= AXIS_HOME;
      r_enQ   <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_axX   <= w_nextAxX;
      r_axY   <= w_nextAxY;
      if (w_vsLead && (r_state == ST_IDLE)) begin
        r_enQ <= I_en;
      end
    end
  end

  // Stage 1: capture HS, the pixel and the inside flag alongside the DE/VS
  // copies held in the position counter.
  always_ff @(posedge I_pxl_clk) begin
    if (I_rst) begin
      r_hs1     <= 1'b0;
      r_inside1 <= 1'b0;
      r_dataR1  <= '0;
      r_dataG1  <= '0;
      r_dataB1  <= '0;
    end else begin
      r_hs1     <= I_hs;
      r_inside1 <= w_inside;
      r_dataR1  <= I_data_r;
      r_dataG1  <= I_data_g;
      r_dataB1  <= I_data_b;
    end
  end

  // Stage 2: substitute the box colour where the pixel is inside the box and
  // the overlay is enabled for this frame; everything else, blanking
  // included, passes through untouched.
  always_ff @(posedge I_pxl_clk) begin
    if (I_rst) begin
      r_vs2    <= 1'b0;
      r_hs2    <= 1'b0;
      r_de2    <= 1'b0;
      r_dataR2 <= '0;
      r_dataG2 <= '0;
      r_dataB2 <= '0;
    end else begin
      r_vs2 <= w_vsPrev;
      r_hs2 <= r_hs1;
      r_de2 <= w_dePrev;
      if (r_inside1 && r_enQ) begin
        r_dataR2 <= I_box_r;
        r_dataG2 <= I_box_g;
        r_dataB2 <= I_box_b;
      end else begin
        r_dataR2 <= r_dataR1;
        r_dataG2 <= r_dataG1;
        r_dataB2 <= r_dataB1;
      end
    end
  end

  assign O_vs         = r_vs2;
  assign O_hs         = r_hs2;
  assign O_de         = r_de2;
  assign O_data_r     = r_dataR2;
  assign O_data_g     = r_dataG2;
  assign O_data_b     = r_dataB2;
  assign O_frame_tick = w_tick;

endmodule
